// File: rtl/msrv32_pkg.sv
// Shared types and constants for the msrv32 fetch front end.
package msrv32_pkg;

    typedef enum logic [1:0] {
        PC_BOOT = 2'b00,
        PC_EPC  = 2'b01,
        PC_TRAP = 2'b10,
        PC_NEXT = 2'b11
    } pc_src_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        HOLD = 2'b11
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/msrv32_next_pc_mux.sv
// Next-PC selection and misaligned-target detection; purely combinational.
// Zero latency, no flow control: the caller samples the result only when it accepts.
module msrv32_next_pc_mux
    import msrv32_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000
) (
    input  pc_src_e     pc_src_i,
    input  logic        branch_taken_i,
    input  logic [31:0] iaddr_i,
    input  logic [31:0] epc_i,
    input  logic [31:0] trap_address_i,
    input  logic [31:0] pc_i,
    output logic [31:0] next_pc_o,
    output logic        misaligned_o
);

    logic [31:0] tgt;

    // Bit 0 is always dropped so JALR targets land on a halfword boundary.
    assign tgt = {iaddr_i[31:1], 1'b0};

    always_comb begin
        next_pc_o    = pc_i + 32'd4;
        misaligned_o = 1'b0;
        case (pc_src_i)
            PC_BOOT: next_pc_o = BOOT_ADDRESS;
            PC_EPC:  next_pc_o = epc_i;
            PC_TRAP: next_pc_o = trap_address_i;
            PC_NEXT: begin
                if (branch_taken_i) begin
                    if (tgt[1]) begin
                        next_pc_o    = trap_address_i;
                        misaligned_o = 1'b1;
                    end else begin
                        next_pc_o = tgt;
                    end
                end
            end
        endcase
    end

endmodule

// File: rtl/msrv32_pc_fetch.sv
// PC register and single-outstanding instruction fetch: REQ -> WAIT -> HOLD, min 3 cycles/instr.
// Backpressure: imreq_ready_in holds the request stable; stall_in freezes HOLD and all outputs.
module msrv32_pc_fetch
    import msrv32_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_n_in,
    input  logic [1:0]  pc_src_in,
    input  logic        branch_taken_in,
    input  logic [31:0] iaddr_in,
    input  logic [31:0] epc_in,
    input  logic [31:0] trap_address_in,
    input  logic        stall_in,
    output logic        imreq_valid_out,
    input  logic        imreq_ready_in,
    output logic [31:0] imaddr_out,
    input  logic        imrsp_valid_in,
    input  logic [31:0] imrsp_data_in,
    output logic [31:0] instr_out,
    output logic        instr_valid_out,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus_4_out,
    output logic        misaligned_instr_out
);

    fetch_state_e state_q;
    logic [31:0]  pc_q;
    logic [31:0]  pc_d;
    logic [31:0]  instr_q;
    logic         req_vld_q;
    logic         instr_vld_q;
    logic         mis_q;
    logic         mis_d;

    msrv32_next_pc_mux #(
        .BOOT_ADDRESS (BOOT_ADDRESS)
    ) u_next_pc_mux (
        .pc_src_i       (pc_src_e'(pc_src_in)),
        .branch_taken_i (branch_taken_in),
        .iaddr_i        (iaddr_in),
        .epc_i          (epc_in),
        .trap_address_i (trap_address_in),
        .pc_i           (pc_q),
        .next_pc_o      (pc_d),
        .misaligned_o   (mis_d)
    );

    // Responses and ready are only honoured in WAIT and REQ respectively, so
    // stragglers from a fetch cut short by reset fall on the floor.
    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
        if (!ms_riscv32_mp_rst_n_in) begin
            state_q     <= IDLE;
            pc_q        <= BOOT_ADDRESS;
            instr_q     <= NOP_INSTR;
            req_vld_q   <= 1'b0;
            instr_vld_q <= 1'b0;
            mis_q       <= 1'b0;
        end else begin
            mis_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    state_q   <= REQ;
                    req_vld_q <= 1'b1;
                end
                REQ: begin
                    if (imreq_ready_in) begin
                        state_q   <= WAIT;
                        req_vld_q <= 1'b0;
                    end
                end
                WAIT: begin
                    if (imrsp_valid_in) begin
                        state_q     <= HOLD;
                        instr_q     <= imrsp_data_in;
                        instr_vld_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (!stall_in) begin
                        state_q     <= REQ;
                        pc_q        <= pc_d;
                        mis_q       <= mis_d;
                        instr_vld_q <= 1'b0;
                        req_vld_q   <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign imreq_valid_out      = req_vld_q;
    assign imaddr_out           = pc_q;
    assign instr_out            = instr_q;
    assign instr_valid_out      = instr_vld_q;
    assign pc_out               = pc_q;
    assign pc_plus_4_out        = pc_q + 32'd4;
    assign misaligned_instr_out = mis_q;

endmodule

// File: tb/tb_msrv32_pc_fetch.sv
// Bench for msrv32_pc_fetch: directed scenarios plus randomized fetch transactions.
module tb_msrv32_pc_fetch;

    localparam logic [31:0] BOOT = 32'h0000_0000;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic [1:0]  pc_src_in;
    logic        branch_taken_in;
    logic [31:0] iaddr_in;
    logic [31:0] epc_in;
    logic [31:0] trap_address_in;
    logic        stall_in;
    logic        imreq_valid_out;
    logic        imreq_ready_in;
    logic [31:0] imaddr_out;
    logic        imrsp_valid_in;
    logic [31:0] imrsp_data_in;
    logic [31:0] instr_out;
    logic        instr_valid_out;
    logic [31:0] pc_out;
    logic [31:0] pc_plus_4_out;
    logic        misaligned_instr_out;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_pc;

    msrv32_pc_fetch #(.BOOT_ADDRESS(BOOT)) dut (
        .ms_riscv32_mp_clk_in   (clk),
        .ms_riscv32_mp_rst_n_in (rst_n),
        .pc_src_in              (pc_src_in),
        .branch_taken_in        (branch_taken_in),
        .iaddr_in               (iaddr_in),
        .epc_in                 (epc_in),
        .trap_address_in        (trap_address_in),
        .stall_in               (stall_in),
        .imreq_valid_out        (imreq_valid_out),
        .imreq_ready_in         (imreq_ready_in),
        .imaddr_out             (imaddr_out),
        .imrsp_valid_in         (imrsp_valid_in),
        .imrsp_data_in          (imrsp_data_in),
        .instr_out              (instr_out),
        .instr_valid_out        (instr_valid_out),
        .pc_out                 (pc_out),
        .pc_plus_4_out          (pc_plus_4_out),
        .misaligned_instr_out   (misaligned_instr_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference next-PC rule: returns {misaligned, next_pc}.
    function automatic logic [32:0] model_next(input logic [1:0] src, input logic br,
                                               input logic [31:0] ia, ep, tr, pc);
        logic [31:0] t;
        t = ia & 32'hFFFF_FFFE;
        if (src == 2'd0) return {1'b0, BOOT};
        if (src == 2'd1) return {1'b0, ep};
        if (src == 2'd2) return {1'b0, tr};
        if (!br)         return {1'b0, pc + 32'd4};
        if ((t % 4) != 0) return {1'b1, tr};
        return {1'b0, t};
    endfunction

    task automatic check_reset_vals();
        check("rst_pc", pc_out, BOOT);
        check("rst_pc4", pc_plus_4_out, BOOT + 32'd4);
        check("rst_req_vld", imreq_valid_out, 0);
        check("rst_instr", instr_out, NOP);
        check("rst_instr_vld", instr_valid_out, 0);
        check("rst_mis", misaligned_instr_out, 0);
    endtask

    task automatic wait_req();
        for (int i = 0; i < 10; i++) begin
            if (imreq_valid_out) break;
            @(negedge clk);
        end
        check("req_seen", imreq_valid_out, 1);
    endtask

    // One complete fetch: request, response, optional stall, then accept with given next-PC inputs.
    task automatic fetch(input int rdy_dly, input int rsp_dly, input int stall_cyc,
                         input logic [31:0] data, input logic [1:0] src, input logic br,
                         input logic [31:0] ia, input logic [31:0] ep, input logic [31:0] tr);
        logic [32:0] m;
        wait_req();
        check("req_addr", imaddr_out, exp_pc);
        for (int i = 0; i < rdy_dly; i++) begin
            imreq_ready_in = 1'b0;
            imrsp_valid_in = 1'($urandom_range(0, 1));
            imrsp_data_in  = $urandom;
            @(negedge clk);
            check("req_hold_vld", imreq_valid_out, 1);
            check("req_hold_addr", imaddr_out, exp_pc);
        end
        imreq_ready_in = 1'b1;
        imrsp_valid_in = 1'($urandom_range(0, 1));
        imrsp_data_in  = $urandom;
        @(negedge clk);
        imreq_ready_in = 1'b0;
        imrsp_valid_in = 1'b0;
        check("wait_req_low", imreq_valid_out, 0);
        check("wait_no_instr", instr_valid_out, 0);
        for (int i = 0; i < rsp_dly; i++) begin
            imreq_ready_in = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("wait_req_low", imreq_valid_out, 0);
            check("wait_no_instr", instr_valid_out, 0);
        end
        imreq_ready_in = 1'b0;
        imrsp_valid_in = 1'b1;
        imrsp_data_in  = data;
        @(negedge clk);
        imrsp_valid_in = 1'b0;
        check("hold_vld", instr_valid_out, 1);
        check("hold_instr", instr_out, data);
        check("hold_pc", pc_out, exp_pc);
        check("hold_pc4", pc_plus_4_out, exp_pc + 32'd4);
        for (int i = 0; i < stall_cyc; i++) begin
            stall_in        = 1'b1;
            pc_src_in       = 2'($urandom_range(0, 3));
            branch_taken_in = 1'($urandom_range(0, 1));
            iaddr_in        = $urandom;
            epc_in          = $urandom;
            trap_address_in = $urandom;
            imrsp_valid_in  = 1'($urandom_range(0, 1));
            imrsp_data_in   = $urandom;
            imreq_ready_in  = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("stall_vld", instr_valid_out, 1);
            check("stall_instr", instr_out, data);
            check("stall_pc", pc_out, exp_pc);
            check("stall_req", imreq_valid_out, 0);
            check("stall_mis", misaligned_instr_out, 0);
        end
        stall_in        = 1'b0;
        imrsp_valid_in  = 1'b0;
        imreq_ready_in  = 1'b0;
        pc_src_in       = src;
        branch_taken_in = br;
        iaddr_in        = ia;
        epc_in          = ep;
        trap_address_in = tr;
        m = model_next(src, br, ia, ep, tr, exp_pc);
        @(negedge clk);
        check("acc_mis", misaligned_instr_out, 32'(m[32]));
        check("acc_vld_low", instr_valid_out, 0);
        check("acc_req", imreq_valid_out, 1);
        check("acc_addr", imaddr_out, m[31:0]);
        exp_pc          = m[31:0];
        pc_src_in       = 2'($urandom_range(0, 3));
        branch_taken_in = 1'($urandom_range(0, 1));
        iaddr_in        = $urandom;
        @(negedge clk);
        check("mis_pulse_end", misaligned_instr_out, 0);
        check("req_still", imaddr_out, exp_pc);
    endtask

    initial begin
        rst_n           = 1'b0;
        pc_src_in       = 2'd3;
        branch_taken_in = 1'b0;
        iaddr_in        = '0;
        epc_in          = '0;
        trap_address_in = '0;
        stall_in        = 1'b0;
        imreq_ready_in  = 1'b0;
        imrsp_valid_in  = 1'b0;
        imrsp_data_in   = '0;
        exp_pc          = BOOT;
        repeat (3) @(negedge clk);
        check_reset_vals();
        rst_n = 1'b1;
        @(negedge clk);
        check("first_req", imreq_valid_out, 1);

        // Sequential fetches at 0,4,8,C with zero-wait memory.
        fetch(0, 0, 0, 32'h0000_0093, 2'd3, 1'b0, '0, '0, '0);
        fetch(0, 0, 0, 32'h0010_0113, 2'd3, 1'b0, '0, '0, '0);
        fetch(1, 2, 0, 32'h0020_0193, 2'd3, 1'b0, '0, '0, '0);
        fetch(0, 0, 0, 32'h0030_0213, 2'd3, 1'b0, '0, '0, '0);
        // Taken branch, bit 0 cleared, aligned.
        fetch(0, 0, 0, 32'h1111_1111, 2'd3, 1'b1, 32'h0000_0101, '0, '0);
        // Taken branch to a halfword-aligned target -> trap.
        fetch(0, 0, 0, 32'h2222_2222, 2'd3, 1'b1, 32'h0000_0206, '0, 32'h0000_0040);
        // Long stall with toggling next-PC inputs.
        fetch(0, 0, 5, 32'h3333_3333, 2'd3, 1'b1, 32'h0000_0800, '0, '0);
        // Wrap from the top of the address space.
        fetch(0, 0, 0, 32'h4444_4444, 2'd1, 1'b0, '0, 32'hFFFF_FFFC, '0);
        fetch(0, 1, 0, 32'h5555_5555, 2'd3, 1'b0, '0, '0, '0);
        // Boot and trap selects, unmasked trap address.
        fetch(2, 0, 1, 32'h6666_6666, 2'd2, 1'b1, '0, '0, 32'h0000_0123);
        fetch(0, 0, 0, 32'h7777_7777, 2'd0, 1'b1, 32'h0000_0006, '0, '0);

        for (int n = 0; n < 40; n++) begin
            fetch($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 4),
                  $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  $urandom, $urandom, $urandom);
        end

        // Reset while waiting for a response; the late response must be dropped.
        wait_req();
        check("pre_rst_addr", imaddr_out, exp_pc);
        imreq_ready_in = 1'b1;
        @(negedge clk);
        imreq_ready_in = 1'b0;
        check("pre_rst_wait", imreq_valid_out, 0);
        rst_n = 1'b0;
        #1;
        check_reset_vals();
        exp_pc = BOOT;
        @(negedge clk);
        rst_n          = 1'b1;
        imrsp_valid_in = 1'b1;
        imrsp_data_in  = 32'hBAD0_BAD0;
        @(negedge clk);
        check("late_rsp_req", imreq_valid_out, 1);
        check("late_rsp_addr", imaddr_out, BOOT);
        check("late_rsp_instr", instr_out, NOP);
        check("late_rsp_vld", instr_valid_out, 0);
        @(negedge clk);
        imrsp_valid_in = 1'b0;
        check("late_rsp_instr2", instr_out, NOP);
        check("late_rsp_vld2", instr_valid_out, 0);
        fetch(0, 0, 0, 32'h0000_0013, 2'd3, 1'b0, '0, '0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
